// File: rtl/fsm_c_cordic_pkg.sv
// Shared definitions for the CORDIC control FSM: state codes, operand and
// adder-source select codes, and the final iteration index.
package fsm_c_cordic_pkg;

  // State encoding; the numeric codes are visible on the debug state ports.
  typedef enum logic [5:0] {
    S_IDLE  = 6'd0,
    S_INIT  = 6'd1,
    S_LOAD  = 6'd2,
    S_SUMX  = 6'd3,
    S_WAITX = 6'd4,
    S_SUMY  = 6'd5,
    S_WAITY = 6'd6,
    S_SNAP  = 6'd7,
    S_SHIFT = 6'd8,
    S_SXI   = 6'd9,
    S_WXI   = 6'd10,
    S_SYI   = 6'd11,
    S_WYI   = 6'd12,
    S_SZI   = 6'd13,
    S_WZI   = 6'd14,
    S_CHECK = 6'd15,
    S_FSUM  = 6'd16,
    S_FWAIT = 6'd17,
    S_DONE  = 6'd18
  } state_e;

  // Operand-A select (MS_2)
  localparam logic [1:0] MS2_X = 2'b00;
  localparam logic [1:0] MS2_Y = 2'b01;
  localparam logic [1:0] MS2_Z = 2'b10;

  // Operand-B select (MS_3)
  localparam logic [1:0] MS3_X = 2'b00;
  localparam logic [1:0] MS3_Y = 2'b01;
  localparam logic [1:0] MS3_Z = 2'b10;

  // Adder source select (MS_4)
  localparam logic [1:0] MS4_INPUT = 2'b00;  // input +/- 1
  localparam logic [1:0] MS4_ITER  = 2'b01;  // iteration operands
  localparam logic [1:0] MS4_ZZ    = 2'b10;  // Z + Z

  // Iteration count at which the loop exits to the final sum
  localparam logic [4:0] ITER_LAST = 5'd15;

endpackage

// File: rtl/fsm_c_cordic.sv
// Control FSM for a floating-point CORDIC datapath. Sequences the initial
// X/Y setup sums, the per-iteration X/Y/Z updates through a shared adder,
// and the final Z+Z sum, then holds ACK_LN until a soft reset.
// Optional macro FSM_DBG_STATE_EN: when defined, state_reg/state_next carry
// the live state codes; otherwise both ports are tied to zero.
module fsm_c_cordic
  import fsm_c_cordic_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_LN,
  input  logic       RST_FSM_LN,
  input  logic       ACK_ADD_SUBT,
  input  logic       Begin_FSM_LN,
  input  logic [4:0] CONT_ITER,
  output logic       RST,
  output logic       MS_1,
  output logic       ADD_SUBT,
  output logic       Begin_SUM,
  output logic [1:0] MS_2,
  output logic [1:0] MS_3,
  output logic [1:0] MS_4,
  output logic       EN_REG1X,
  output logic       EN_REG1Y,
  output logic       EN_REG1Z,
  output logic       EN_REG2,
  output logic       EN_REG2XYZ,
  output logic       EN_REG3,
  output logic       EN_REG4,
  output logic       CLK_CDIR,
  output logic       ACK_LN,
  output logic [5:0] state_reg,
  output logic [5:0] state_next
);

  state_e state_q, state_d;

  // State register; RST_LN abandons any computation and returns to IDLE
  always_ff @(posedge CLK or posedge RST_LN) begin
    if (RST_LN) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and output decode. Outputs follow the current state, except
  // the WAIT-state register enables, which fire only in the cycle the adder
  // acknowledges so each result is captured exactly once.
  always_comb begin
    state_d    = state_q;
    RST        = 1'b0;
    MS_1       = 1'b0;
    ADD_SUBT   = 1'b0;
    Begin_SUM  = 1'b0;
    MS_2       = MS2_X;
    MS_3       = MS3_X;
    MS_4       = MS4_INPUT;
    EN_REG1X   = 1'b0;
    EN_REG1Y   = 1'b0;
    EN_REG1Z   = 1'b0;
    EN_REG2    = 1'b0;
    EN_REG2XYZ = 1'b0;
    EN_REG3    = 1'b0;
    EN_REG4    = 1'b0;
    CLK_CDIR   = 1'b0;
    ACK_LN     = 1'b0;
    case (state_q)
      S_IDLE:  if (Begin_FSM_LN) state_d = S_INIT;
      S_INIT: begin
        RST     = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        EN_REG3 = 1'b1;
        state_d = S_SUMX;
      end
      S_SUMX: begin
        MS_4      = MS4_INPUT;
        Begin_SUM = 1'b1;
        state_d   = S_WAITX;
      end
      S_WAITX: if (ACK_ADD_SUBT) begin
        EN_REG1X = 1'b1;
        state_d  = S_SUMY;
      end
      S_SUMY: begin
        MS_4      = MS4_INPUT;
        ADD_SUBT  = 1'b1;
        Begin_SUM = 1'b1;
        state_d   = S_WAITY;
      end
      // Z is loaded alongside Y so it starts from a cleared value
      S_WAITY: if (ACK_ADD_SUBT) begin
        EN_REG1Y = 1'b1;
        EN_REG1Z = 1'b1;
        state_d  = S_SNAP;
      end
      S_SNAP: begin
        EN_REG2XYZ = 1'b1;
        state_d    = S_SHIFT;
      end
      // CLK_CDIR also advances the external iteration counter
      S_SHIFT: begin
        EN_REG2  = 1'b1;
        CLK_CDIR = 1'b1;
        state_d  = S_SXI;
      end
      S_SXI: begin
        MS_4      = MS4_ITER;
        MS_2      = MS2_X;
        MS_3      = MS3_Y;
        Begin_SUM = 1'b1;
        state_d   = S_WXI;
      end
      S_WXI: begin
        MS_1 = 1'b1;
        if (ACK_ADD_SUBT) begin
          EN_REG1X = 1'b1;
          state_d  = S_SYI;
        end
      end
      S_SYI: begin
        MS_4      = MS4_ITER;
        MS_2      = MS2_Y;
        MS_3      = MS3_X;
        Begin_SUM = 1'b1;
        state_d   = S_WYI;
      end
      S_WYI: begin
        MS_1 = 1'b1;
        if (ACK_ADD_SUBT) begin
          EN_REG1Y = 1'b1;
          state_d  = S_SZI;
        end
      end
      S_SZI: begin
        MS_4      = MS4_ITER;
        MS_2      = MS2_Z;
        MS_3      = MS3_Z;
        Begin_SUM = 1'b1;
        state_d   = S_WZI;
      end
      S_WZI: begin
        MS_1 = 1'b1;
        if (ACK_ADD_SUBT) begin
          EN_REG1Z = 1'b1;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: state_d = (CONT_ITER == ITER_LAST) ? S_FSUM : S_SNAP;
      S_FSUM: begin
        MS_4      = MS4_ZZ;
        Begin_SUM = 1'b1;
        state_d   = S_FWAIT;
      end
      S_FWAIT: if (ACK_ADD_SUBT) begin
        EN_REG4 = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  ACK_LN = 1'b1;
      default: state_d = S_IDLE;
    endcase
    // Soft reset wins over every transition, including the hold in DONE
    if (RST_FSM_LN) state_d = S_IDLE;
  end

`ifdef FSM_DBG_STATE_EN
  assign state_reg  = state_q;
  assign state_next = state_d;
`else
  assign state_reg  = 6'd0;
  assign state_next = 6'd0;
`endif

endmodule

// File: tb/tb_fsm_c_cordic.sv
// Directed bench for fsm_c_cordic. Outputs are packed into one vector and
// compared against a hand-written per-state table (ACK_ADD_SUBT high).
module tb_fsm_c_cordic;

  logic       CLK = 1'b0;
  logic       RST_LN, RST_FSM_LN, ACK_ADD_SUBT, Begin_FSM_LN;
  logic [4:0] CONT_ITER;
  logic       RST, MS_1, ADD_SUBT, Begin_SUM;
  logic [1:0] MS_2, MS_3, MS_4;
  logic       EN_REG1X, EN_REG1Y, EN_REG1Z, EN_REG2, EN_REG2XYZ, EN_REG3, EN_REG4;
  logic       CLK_CDIR, ACK_LN;
  logic [5:0] state_reg, state_next;

  fsm_c_cordic dut (
    .CLK(CLK), .RST_LN(RST_LN), .RST_FSM_LN(RST_FSM_LN), .ACK_ADD_SUBT(ACK_ADD_SUBT),
    .Begin_FSM_LN(Begin_FSM_LN), .CONT_ITER(CONT_ITER), .RST(RST), .MS_1(MS_1),
    .ADD_SUBT(ADD_SUBT), .Begin_SUM(Begin_SUM), .MS_2(MS_2), .MS_3(MS_3), .MS_4(MS_4),
    .EN_REG1X(EN_REG1X), .EN_REG1Y(EN_REG1Y), .EN_REG1Z(EN_REG1Z), .EN_REG2(EN_REG2),
    .EN_REG2XYZ(EN_REG2XYZ), .EN_REG3(EN_REG3), .EN_REG4(EN_REG4), .CLK_CDIR(CLK_CDIR),
    .ACK_LN(ACK_LN), .state_reg(state_reg), .state_next(state_next)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  // {RST MS_1 ADD_SUBT Begin_SUM}_{MS_2}_{MS_3}_{MS_4}_{EN1X EN1Y EN1Z}_{EN2 EN2XYZ EN3 EN4}_{CDIR ACK_LN}
  logic [18:0] obs;
  assign obs = {RST, MS_1, ADD_SUBT, Begin_SUM, MS_2, MS_3, MS_4, EN_REG1X, EN_REG1Y,
                EN_REG1Z, EN_REG2, EN_REG2XYZ, EN_REG3, EN_REG4, CLK_CDIR, ACK_LN};

  logic [18:0] exp_tab [0:18];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Debug state ports show the code only when the debug macro is built in
  task automatic chk_st(input string tag, input int s);
    int want;
`ifdef FSM_DBG_STATE_EN
    want = s;
`else
    want = 0;
`endif
    chk(tag, 32'(state_reg), 32'(want));
  endtask

  // Advance one edge and land on the following falling edge for sampling
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  function automatic int loop_state(input int e);
    if (e <= 15)      return e;
    else if (e <= 42) return 7 + ((e - 16) % 9);
    else              return 16 + (e - 43);
  endfunction

  initial begin
    exp_tab[0]  = 19'b0000_00_00_00_000_0000_00;
    exp_tab[1]  = 19'b1000_00_00_00_000_0000_00;
    exp_tab[2]  = 19'b0000_00_00_00_000_0010_00;
    exp_tab[3]  = 19'b0001_00_00_00_000_0000_00;
    exp_tab[4]  = 19'b0000_00_00_00_100_0000_00;
    exp_tab[5]  = 19'b0011_00_00_00_000_0000_00;
    exp_tab[6]  = 19'b0000_00_00_00_011_0000_00;
    exp_tab[7]  = 19'b0000_00_00_00_000_0100_00;
    exp_tab[8]  = 19'b0000_00_00_00_000_1000_10;
    exp_tab[9]  = 19'b0001_00_01_01_000_0000_00;
    exp_tab[10] = 19'b0100_00_00_00_100_0000_00;
    exp_tab[11] = 19'b0001_01_00_01_000_0000_00;
    exp_tab[12] = 19'b0100_00_00_00_010_0000_00;
    exp_tab[13] = 19'b0001_10_10_01_000_0000_00;
    exp_tab[14] = 19'b0100_00_00_00_001_0000_00;
    exp_tab[15] = 19'b0000_00_00_00_000_0000_00;
    exp_tab[16] = 19'b0001_00_00_10_000_0000_00;
    exp_tab[17] = 19'b0000_00_00_00_000_0001_00;
    exp_tab[18] = 19'b0000_00_00_00_000_0000_01;

    RST_LN = 1'b1; RST_FSM_LN = 1'b0; ACK_ADD_SUBT = 1'b0;
    Begin_FSM_LN = 1'b0; CONT_ITER = 5'd0;

    // Reset state
    @(negedge CLK);
    @(negedge CLK);
    chk("reset_outputs", 32'(obs), 32'd0);
    chk_st("reset_state", 0);
    chk("reset_next", 32'(state_next), 32'd0);
    RST_LN = 1'b0;

    // Single pass: one state per edge, DONE at edge 18; Begin mid-run ignored
    ACK_ADD_SUBT = 1'b1; CONT_ITER = 5'd15; Begin_FSM_LN = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      tick();
      Begin_FSM_LN = (e == 4);
      chk($sformatf("pass1_e%0d_out", e), 32'(obs), 32'(exp_tab[e]));
      chk_st($sformatf("pass1_e%0d_st", e), e);
    end
    // DONE holds without soft reset
    tick();
    chk("done_hold_out", 32'(obs), 32'(exp_tab[18]));
    chk_st("done_hold_st", 18);

    // Soft reset from DONE
    RST_FSM_LN = 1'b1;
    tick();
    RST_FSM_LN = 1'b0;
    chk("soft_rst_ack_ln", 32'(ACK_LN), 32'd0);
    chk_st("soft_rst_st", 0);
    tick();
    chk("idle_no_begin", 32'(obs), 32'd0);

    // Looping: CONT_ITER becomes 15 after edge 40, exit at CHECK of edge 42
    CONT_ITER = 5'd0; Begin_FSM_LN = 1'b1;
    for (int e = 1; e <= 45; e++) begin
      if (e == 41) CONT_ITER = 5'd15;
      tick();
      Begin_FSM_LN = 1'b0;
      chk($sformatf("loop_e%0d_out", e), 32'(obs), 32'(exp_tab[loop_state(e)]));
      chk_st($sformatf("loop_e%0d_st", e), loop_state(e));
    end
    RST_FSM_LN = 1'b1;
    tick();
    RST_FSM_LN = 1'b0;

    // WAITX stall: ACK low keeps state and suppresses EN_REG1X
    ACK_ADD_SUBT = 1'b0; Begin_FSM_LN = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      Begin_FSM_LN = 1'b0;
    end
    chk("pre_waitx_out", 32'(obs), 32'(exp_tab[3]));
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("waitx_stall%0d_out", c), 32'(obs), 32'd0);
      chk_st($sformatf("waitx_stall%0d_st", c), 4);
    end
    ACK_ADD_SUBT = 1'b1;
    #1;
    chk("waitx_ack_en", 32'(obs), 32'(exp_tab[4]));
    @(negedge CLK);
    chk("after_waitx_out", 32'(obs), 32'(exp_tab[5]));
    chk("after_waitx_en1x", 32'(EN_REG1X), 32'd0);
    chk_st("after_waitx_st", 5);
    tick(); tick();
    chk("pre_async_out", 32'(obs), 32'(exp_tab[7]));

    // Async reset mid-operation, away from any clock edge
    #2 RST_LN = 1'b1;
    #1;
    chk("async_rst_out", 32'(obs), 32'd0);
    chk_st("async_rst_st", 0);
    @(negedge CLK);
    RST_LN = 1'b0;
    for (int c = 0; c < 25; c++) tick();
    chk("post_async_idle_out", 32'(obs), 32'd0);
    chk_st("post_async_idle_st", 0);

    // Soft reset mid-computation
    Begin_FSM_LN = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      Begin_FSM_LN = 1'b0;
    end
    chk("pre_soft_out", 32'(obs), 32'(exp_tab[6]));
    RST_FSM_LN = 1'b1;
    tick();
    RST_FSM_LN = 1'b0;
    chk("soft_mid_out", 32'(obs), 32'd0);
    chk_st("soft_mid_st", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
